// File: rtl/key_router.sv
// key_router: turns debounced key levels into mode selection, clock-mode
// pulses and multiplier operand updates. Every output is registered, so an
// output changes on the clk edge that first samples the rising key level.
// Optional feature macro: KEY_ROUTER_REPEAT_EN (auto-repeat of A/B/C while held).
//
// mode | meaning
// -----+--------------------------------------------------
//    0 | idle, keys other than MODE ignored
//    1 | idle, keys other than MODE ignored
//    2 | CLOCK: A/B/C/E pulse hour/min/sec/clc, D toggles run
//    3 | MUL: A/B bump op_x/op_y, C toggles show, D clears
//   4+ | idle, keys other than MODE ignored
module key_router #(
   parameter int NKEY    = 7,
   parameter int NMODE   = 4,
   parameter int OPW     = 4,
   parameter int REP_DLY = 8,
   parameter int REP_PER = 4,
   localparam int MW     = $clog2(NMODE)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NKEY-1:0] key_lvl,
   output logic [MW-1:0]   mode,
   output logic            mode_chg,
   output logic            hour_up,
   output logic            min_up,
   output logic            sec_up,
   output logic            clc,
   output logic            run,
   output logic [OPW-1:0]  op_x,
   output logic [OPW-1:0]  op_y,
   output logic            show
);

   logic [NKEY-1:0] prev_q;
   logic [NKEY-1:0] press_raw;
   logic [4:0]      press_eff;
   logic            mode_press;
   logic            in_clk;
   logic            in_mul;

   logic [MW-1:0]   mode_q,   mode_n;
   logic            chg_q,    chg_n;
   logic            hour_q,   hour_n;
   logic            min_q,    min_n;
   logic            sec_q,    sec_n;
   logic            clc_q,    clc_n;
   logic            run_q,    run_n;
   logic [OPW-1:0]  opx_q,    opx_n;
   logic [OPW-1:0]  opy_q,    opy_n;
   logic            show_q,   show_n;

   assign press_raw  = key_lvl & ~prev_q;
   assign mode_press = press_raw[NKEY-1];
   // Compare at 32 bits so modes 2/3 are simply never matched when MW is too narrow.
   assign in_clk     = (32'(mode_q) == 32'd2);
   assign in_mul     = (32'(mode_q) == 32'd3);

`ifdef KEY_ROUTER_REPEAT_EN
   localparam int RMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
   localparam int CW   = $clog2(RMAX + 1);

   logic          rep_arm_q, rep_arm_n;
   logic [2:0]    rep_sel_q, rep_sel_n;
   logic [CW-1:0] rep_cnt_q, rep_cnt_n;
   logic [2:0]    held_sel;
   logic [2:0]    rep_fire;

   // Lowest-index held key among A/B/C, one-hot.
   assign held_sel = key_lvl[2:0] & (~key_lvl[2:0] + 3'd1);

   // Repeat timer: armed only by a real press, dropped on mode change,
   // leaving mode 2/3, or when the repeating key stops being the lowest held.
   always_comb begin
      rep_arm_n = rep_arm_q;
      rep_sel_n = rep_sel_q;
      rep_cnt_n = rep_cnt_q;
      rep_fire  = 3'b000;
      if (mode_press || !(in_clk || in_mul) || (held_sel == 3'b000)) begin
         rep_arm_n = 1'b0;
      end else if (|press_raw[4:0]) begin
         rep_arm_n = 1'b1;
         rep_sel_n = held_sel;
         rep_cnt_n = CW'(REP_DLY - 1);
      end else if (rep_arm_q && (held_sel != rep_sel_q)) begin
         rep_arm_n = 1'b0;
      end else if (rep_arm_q) begin
         if (rep_cnt_q == '0) begin
            rep_fire  = rep_sel_q;
            rep_cnt_n = CW'(REP_PER - 1);
         end else begin
            rep_cnt_n = rep_cnt_q - CW'(1);
         end
      end
   end

   // Repeat timer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_arm_q <= 1'b0;
         rep_sel_q <= 3'b000;
         rep_cnt_q <= '0;
      end else begin
         rep_arm_q <= rep_arm_n;
         rep_sel_q <= rep_sel_n;
         rep_cnt_q <= rep_cnt_n;
      end
   end

   assign press_eff = press_raw[4:0] | {2'b00, rep_fire};
`else
   assign press_eff = press_raw[4:0];
`endif

   // State register: edge history and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '1;
         mode_q <= '0;
         chg_q  <= 1'b0;
         hour_q <= 1'b0;
         min_q  <= 1'b0;
         sec_q  <= 1'b0;
         clc_q  <= 1'b0;
         run_q  <= 1'b0;
         opx_q  <= '0;
         opy_q  <= '0;
         show_q <= 1'b0;
      end else begin
         prev_q <= key_lvl;
         mode_q <= mode_n;
         chg_q  <= chg_n;
         hour_q <= hour_n;
         min_q  <= min_n;
         sec_q  <= sec_n;
         clc_q  <= clc_n;
         run_q  <= run_n;
         opx_q  <= opx_n;
         opy_q  <= opy_n;
         show_q <= show_n;
      end
   end

   // Next state: a MODE press wins and swallows every other key that cycle.
   always_comb begin
      mode_n = mode_q;
      chg_n  = 1'b0;
      hour_n = 1'b0;
      min_n  = 1'b0;
      sec_n  = 1'b0;
      clc_n  = 1'b0;
      run_n  = run_q;
      opx_n  = opx_q;
      opy_n  = opy_q;
      show_n = show_q;
      if (mode_press) begin
         chg_n = 1'b1;
         if (32'(mode_q) == NMODE - 1) begin
            mode_n = '0;
         end else begin
            mode_n = mode_q + MW'(1);
         end
      end else if (in_clk) begin
         hour_n = press_eff[0];
         min_n  = press_eff[1];
         sec_n  = press_eff[2];
         clc_n  = press_eff[4];
         run_n  = run_q ^ press_eff[3];
      end else if (in_mul) begin
         if (press_eff[3]) begin
            opx_n  = '0;
            opy_n  = '0;
            show_n = 1'b0;
         end else begin
            opx_n  = opx_q + OPW'(press_eff[0]);
            opy_n  = opy_q + OPW'(press_eff[1]);
            show_n = show_q ^ press_eff[2];
         end
      end
   end

   // Outputs come straight from the registers.
   always_comb begin
      mode     = mode_q;
      mode_chg = chg_q;
      hour_up  = hour_q;
      min_up   = min_q;
      sec_up   = sec_q;
      clc      = clc_q;
      run      = run_q;
      op_x     = opx_q;
      op_y     = opy_q;
      show     = show_q;
   end

endmodule

// File: tb/tb_key_router.sv
// Bench for key_router: directed key sequences followed by random key
// traffic, all scored against a reference model via an expectation queue.
module tb_key_router;
   localparam int NKEY    = 7;
   localparam int NMODE   = 4;
   localparam int OPW     = 4;
   localparam int REP_DLY = 8;
   localparam int REP_PER = 4;
   localparam int MW      = $clog2(NMODE);

   localparam logic [NKEY-1:0] KA = 7'b0000001;
   localparam logic [NKEY-1:0] KB = 7'b0000010;
   localparam logic [NKEY-1:0] KC = 7'b0000100;
   localparam logic [NKEY-1:0] KD = 7'b0001000;
   localparam logic [NKEY-1:0] KE = 7'b0010000;
   localparam logic [NKEY-1:0] KM = 7'b1000000;
   localparam logic [NKEY-1:0] K0 = 7'b0000000;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NKEY-1:0] key_lvl;
   logic [MW-1:0]   mode;
   logic            mode_chg, hour_up, min_up, sec_up, clc, run, show;
   logic [OPW-1:0]  op_x, op_y;

   key_router #(.NKEY(NKEY), .NMODE(NMODE), .OPW(OPW),
                .REP_DLY(REP_DLY), .REP_PER(REP_PER)) dut (
      .clk(clk), .rst_n(rst_n), .key_lvl(key_lvl), .mode(mode),
      .mode_chg(mode_chg), .hour_up(hour_up), .min_up(min_up),
      .sec_up(sec_up), .clc(clc), .run(run), .op_x(op_x), .op_y(op_y),
      .show(show));

   always #5 clk = ~clk;

   typedef struct {
      int mode; bit chg; bit hour; bit min; bit sec; bit clc;
      bit run; int opx; int opy; bit show;
   } exp_t;

   exp_t exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [NKEY-1:0] m_prev;
   int m_mode, m_opx, m_opy;
   bit m_run, m_show;
   bit m_rep_on;
   int m_rep_key, m_age;

   task automatic cmp(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic void model_reset();
      m_prev = '1; m_mode = 0; m_opx = 0; m_opy = 0;
      m_run = 0; m_show = 0; m_rep_on = 0; m_rep_key = -1; m_age = 0;
   endfunction

   // Predict outputs after the next rising edge that samples k.
   function automatic void model_step(input logic [NKEY-1:0] k);
      exp_t e;
      logic [NKEY-1:0] p;
      bit [4:0] ev;
      int held;
      p = k & ~m_prev;
      m_prev = k;
      ev = p[4:0];
      held = k[0] ? 0 : k[1] ? 1 : k[2] ? 2 : -1;
`ifdef KEY_ROUTER_REPEAT_EN
      if (p[NKEY-1] || !(m_mode == 2 || m_mode == 3) || held < 0) m_rep_on = 0;
      else if (p[4:0] != 0) begin m_rep_on = 1; m_age = 0; m_rep_key = held; end
      else if (m_rep_on && held != m_rep_key) m_rep_on = 0;
      else if (m_rep_on) begin
         m_age++;
         if (m_age == REP_DLY || (m_age > REP_DLY && (m_age - REP_DLY) % REP_PER == 0))
            ev[m_rep_key] = 1'b1;
      end
`endif
      e.chg = 0; e.hour = 0; e.min = 0; e.sec = 0; e.clc = 0;
      if (p[NKEY-1]) begin
         m_mode = (m_mode + 1) % NMODE;
         e.chg = 1;
      end else if (m_mode == 2) begin
         e.hour = ev[0]; e.min = ev[1]; e.sec = ev[2]; e.clc = ev[4];
         if (ev[3]) m_run = !m_run;
      end else if (m_mode == 3) begin
         if (ev[3]) begin
            m_opx = 0; m_opy = 0; m_show = 0;
         end else begin
            m_opx = (m_opx + int'(ev[0])) % (1 << OPW);
            m_opy = (m_opy + int'(ev[1])) % (1 << OPW);
            if (ev[2]) m_show = !m_show;
         end
      end
      e.mode = m_mode; e.run = m_run; e.opx = m_opx; e.opy = m_opy; e.show = m_show;
      exp_q.push_back(e);
   endfunction

   task automatic step(input logic [NKEY-1:0] k);
      @(negedge clk);
      key_lvl = k;
      model_step(k);
   endtask

   task automatic press_rel(input logic [NKEY-1:0] k);
      step(k);
      step(K0);
   endtask

   task automatic check_zero(input string tag);
      cmp({tag, "_mode"}, int'(mode), 0);
      cmp({tag, "_pulses"}, int'({mode_chg, hour_up, min_up, sec_up, clc}), 0);
      cmp({tag, "_run"}, int'(run), 0);
      cmp({tag, "_opx"}, int'(op_x), 0);
      cmp({tag, "_opy"}, int'(op_y), 0);
      cmp({tag, "_show"}, int'(show), 0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: the DUT presents a full output set every cycle out of reset.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("mode", int'(mode), e.mode);
            cmp("mode_chg", int'(mode_chg), int'(e.chg));
            cmp("hour_up", int'(hour_up), int'(e.hour));
            cmp("min_up", int'(min_up), int'(e.min));
            cmp("sec_up", int'(sec_up), int'(e.sec));
            cmp("clc", int'(clc), int'(e.clc));
            cmp("run", int'(run), int'(e.run));
            cmp("op_x", int'(op_x), e.opx);
            cmp("op_y", int'(op_y), e.opy);
            cmp("show", int'(show), int'(e.show));
         end
      end
   end

   initial begin
      logic [NKEY-1:0] k;
      rst_n = 1'b0;
      key_lvl = KA;
      model_reset();
      #3;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_step(key_lvl);

      // A held through reset: nothing until released and pressed again
      step(KA); step(KA); step(K0);
      press_rel(KA);

      // mode walk 1,2,3,0
      repeat (4) press_rel(KM);
      settle();
      cmp("mode_wrap", int'(mode), 0);

      // MUL mode: wrap op_x, A+B together, D overrides A
      repeat (3) press_rel(KM);
      repeat (16) press_rel(KA);
      settle();
      cmp("opx_wrap16", int'(op_x), 0);
      press_rel(KA | KB);
      press_rel(KC);
      press_rel(KD | KA);
      settle();
      cmp("clr_opx", int'(op_x), 0);
      cmp("clr_opy", int'(op_y), 0);
      cmp("clr_show", int'(show), 0);
      press_rel(KA); press_rel(KA);

      // CLOCK mode: A+E, D twice, then MODE+A
      repeat (3) press_rel(KM);
      press_rel(KA | KE);
      press_rel(KD);
      press_rel(KD);
      press_rel(KM | KA);
      settle();
      cmp("modeA_mode", int'(mode), 3);
      cmp("modeA_opx", int'(op_x), 2);

      // hold A for a long time in MUL mode
      repeat (21) step(KA);
      step(K0);
      settle();
`ifdef KEY_ROUTER_REPEAT_EN
      cmp("hold_opx", int'(op_x), 7);
`else
      cmp("hold_opx", int'(op_x), 3);
`endif

      // reset in the middle of a held key
      step(KB); step(KB);
      settle();
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      model_step(key_lvl);
      repeat (12) step(KB);
      step(K0);

      // random key traffic
      k = K0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < NKEY - 1; b++)
            if ($urandom_range(0, 3) == 0) k[b] = ~k[b];
         if ($urandom_range(0, 15) == 0) k[NKEY-1] = ~k[NKEY-1];
         step(k);
      end
      step(K0);
      repeat (2) @(posedge clk);
      #2;
      cmp("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/key_router.md
KEY_ROUTER -- requirements
Module: key_router

Interface
REQ-001 SHALL provide parameter NKEY, default 7: number of debounced key inputs, minimum 6.
REQ-002 SHALL provide parameter NMODE, default 4: number of modes, 2..16.
REQ-003 SHALL provide parameter OPW, default 4: operand width, 2..16.
REQ-004 SHALL provide parameters REP_DLY, default 8, and REP_PER, default 4: auto-repeat hold delay and period in clk cycles.
REQ-005 SHALL provide the following ports.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- key_lvl  in  NKEY  debounced key levels, 1 = pressed.
- mode  out  clog2(NMODE)  current mode.
- mode_chg  out  1  one-cycle pulse on each mode change.
- hour_up, min_up, sec_up, clc  out  1 each  clock-mode one-cycle pulses.
- run  out  1  clock run/pause level.
- op_x, op_y  out  OPW each  multiplier operands.
- show  out  1  multiplier result-display level.

Function
REQ-006 SHALL register key_lvl each cycle into prev; press[i] = key_lvl[i] & ~prev[i].
REQ-007 SHALL map keys as follows: key 0 = A, key 1 = B, key 2 = C, key 3 = D, key 4 = E, key NKEY-1 = MODE; keys 5..NKEY-2 are ignored.
REQ-008 SHALL update every output on the clk edge at which the press is first sampled, giving one cycle of latency from key_lvl rising.
REQ-009 A MODE press SHALL increment mode, wrap NMODE-1 -> 0, and pulse mode_chg; every other press in that cycle SHALL be discarded.
REQ-010 In mode 2 (CLOCK), A/B/C presses SHALL pulse hour_up/min_up/sec_up, E SHALL pulse clc, and D SHALL toggle run.
- Simultaneous presses all take effect.
REQ-011 In mode 3 (MUL), D SHALL clear op_x, op_y and show to 0 and override all other keys that cycle.
- Otherwise A increments op_x and B increments op_y, both modulo 2^OPW, and both may act in the same cycle.
- C toggles show.
REQ-012 In any other mode, keys SHALL have no effect; run, op_x, op_y and show SHALL hold in every mode except where changed above.
REQ-013 Pulse outputs SHALL be 0 in every cycle without a qualifying event, and never high for two consecutive cycles from a single press.
REQ-014 When NMODE < 4, modes 2/3 that do not exist SHALL simply be unreachable, with no error.

Reset
REQ-015 rst_n low SHALL asynchronously set mode, op_x, op_y and all pulse outputs to 0, run to 0 and show to 0.
REQ-016 Reset SHALL set prev to all ones, so a key held through reset generates no press until released and re-pressed.
REQ-017 Reset asserted mid-hold SHALL clear the repeat counter; no repeat SHALL occur before a fresh press.

Configuration
REQ-018 With macro KEY_ROUTER_REPEAT_EN defined, holding A, B or C in mode 2 or 3 SHALL generate a synthetic press REP_DLY cycles after the real press, then one every REP_PER cycles while held.
- Only the lowest-index held key among A/B/C repeats.
- Release, a mode change or any new press restarts the counter.
REQ-019 Without KEY_ROUTER_REPEAT_EN, the repeat counter logic SHALL be absent and each physical press SHALL yield exactly one event.

Verification
(defaults throughout)
REQ-020 Four MODE presses from reset -> mode sequence 1, 2, 3, 0, with four mode_chg pulses of 1 cycle each.
REQ-021 Mode 3, sixteen A presses -> op_x reaches 15 then wraps to 0; A and B pressed in the same cycle -> op_x and op_y both increment; D+A same cycle -> op_x=0, op_y=0, show=0.
REQ-022 Mode 2, A+E same cycle -> hour_up and clc pulse together for 1 cycle; D pressed twice -> run 0 -> 1 -> 0.
REQ-023 MODE+A same cycle in mode 2 -> mode becomes 3, no hour_up pulse, op_x unchanged.
REQ-024 Key A held from before rst_n release -> no event until released and re-pressed.
REQ-025 With KEY_ROUTER_REPEAT_EN, mode 3, A held 20 cycles -> op_x increments at press, +8, +12, +16 and +20 cycles (5 total); without the macro -> 1 increment.
